// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The optional trailing checksum is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_pkg;

    localparam int DEPTH          = 64;
    localparam int ADDR_W         = 6;
    localparam int N_DEF          = 32;
    localparam int BYTES_PER_WORD = N_DEF / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        LOAD  = 3'd2,
        WRITE = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_e;

    // Running XOR of program bytes; the sender appends the same value.
    function automatic logic [7:0] xor_byte(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/word_packer.sv
// Little-endian byte-to-word packer: the first byte of a word lands in bits 7:0.
// word_next/word_done describe the word completed by the byte shifted in this cycle.
module word_packer
    import imem_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         shift,
    input  logic [7:0]   byte_in,
    output logic [N-1:0] word_next,
    output logic         word_done
);

    localparam int BYTES = N / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [N-1:0]     word_r;
    logic [CNT_W-1:0] cnt_r;
    logic [N-1:0]     shifted_s;

    generate
        if (N == 8) begin : g_single
            assign shifted_s = byte_in;
        end else begin : g_multi
            assign shifted_s = {byte_in, word_r[N-1:8]};
        end
    endgenerate

    // Word-complete flag and the fully assembled word for the loader to latch.
    always_comb begin
        word_next = shifted_s;
        word_done = 1'b0;
        if (shift && (cnt_r == CNT_W'(BYTES - 1))) begin
            word_done = 1'b1;
        end else begin
            word_done = 1'b0;
        end
    end

    // Shift register and byte counter; clear restarts a fresh word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_r <= '0;
            cnt_r  <= '0;
        end else if (clear) begin
            word_r <= '0;
            cnt_r  <= '0;
        end else if (shift) begin
            word_r <= shifted_s;
            cnt_r  <= word_done ? '0 : cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: length header, N-bit words written to instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [N-1:0]      wdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_e       state_r;
    state_e       next_s;
    logic [6:0]   len_r;
    logic [6:0]   word_idx_r;
    logic         accept_s;
    logic         start_ok_s;
    logic         shift_s;
    logic         last_word_s;
    logic         len_ok_s;
    logic         word_done_s;
    logic [N-1:0] word_next_s;

    assign accept_s    = rx_valid & rx_ready;
    assign start_ok_s  = start & ((state_r == IDLE) | (state_r == DONE) | (state_r == ERR));
    assign shift_s     = accept_s & (state_r == LOAD);
    assign last_word_s = ((word_idx_r + 7'd1) >= len_r);
    assign len_ok_s    = (rx_data != 8'd0) && (rx_data <= 8'(DEPTH));

    word_packer #(.N(N)) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok_s),
        .shift     (shift_s),
        .byte_in   (rx_data),
        .word_next (word_next_s),
        .word_done (word_done_s)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] cksum_r;

    // Checksum covers data bytes only, never the length header.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cksum_r <= 8'd0;
        end else if (start_ok_s) begin
            cksum_r <= 8'd0;
        end else if (shift_s) begin
            cksum_r <= xor_byte(cksum_r, rx_data);
        end
    end
`endif

    // Next-state decode.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE, DONE, ERR: begin
                if (start) next_s = HDR;
                else       next_s = state_r;
            end
            HDR: begin
                if (accept_s) next_s = len_ok_s ? LOAD : ERR;
                else          next_s = HDR;
            end
            LOAD: begin
                if (shift_s && word_done_s) next_s = WRITE;
                else                        next_s = LOAD;
            end
            WRITE: begin
                if (last_word_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    next_s = CHECK;
`else
                    next_s = DONE;
`endif
                end else begin
                    next_s = LOAD;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept_s) next_s = (rx_data == cksum_r) ? DONE : ERR;
                else          next_s = CHECK;
            end
`endif
            default: next_s = IDLE;
        endcase
    end

    // State, length and word index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            len_r      <= 7'd0;
            word_idx_r <= 7'd0;
        end else begin
            state_r <= next_s;
            if (start_ok_s) begin
                len_r      <= 7'd0;
                word_idx_r <= 7'd0;
            end else if ((state_r == HDR) && accept_s) begin
                len_r <= rx_data[6:0];
            end else if (state_r == WRITE) begin
                word_idx_r <= word_idx_r + 7'd1;
            end
        end
    end

    // Outputs are registered from the next state so they line up with state_r.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ready <= 1'b0;
            we       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
        end else begin
            rx_ready <= (next_s == HDR) | (next_s == LOAD) | (next_s == CHECK);
            we       <= (next_s == WRITE);
            busy     <= (next_s == HDR) | (next_s == LOAD) | (next_s == WRITE) | (next_s == CHECK);
            done     <= (next_s == DONE);
            error    <= (next_s == ERR);
            if ((state_r == LOAD) && (next_s == WRITE)) begin
                waddr <= word_idx_r[ADDR_W-1:0];
                wdata <= word_next_s;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; covers the checksum path
// when IMEM_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        error;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [5:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  tb_ck;

    imem_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Write monitor: records every write and checks the port is closed meanwhile.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wr_addr_q.push_back(waddr);
            wr_data_q.push_back(wdata);
            vec_cnt++;
            if (rx_ready !== 1'b0) begin
                err_cnt++;
                $display("FAIL write_rx_ready got %b want 0", rx_ready);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (rx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            err_cnt++;
            $display("FAIL send_byte_timeout got rx_ready=%b want 1", rx_ready);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gap);
            tb_ck = tb_ck ^ w[8*i +: 8];
        end
    endtask

    task automatic begin_load(input logic [7:0] len);
        wr_addr_q.delete();
        wr_data_q.delete();
        tb_ck = 8'd0;
        pulse_start();
        send_byte(len, 0);
    endtask

    task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(tb_ck, 0);
`endif
        repeat (4) @(negedge clk);
    endtask

    task automatic check_ends(input string name, input logic exp_done, input logic exp_err);
        vec_cnt += 3;
        if (done !== exp_done) begin
            err_cnt++;
            $display("FAIL %s_done got %b want %b", name, done, exp_done);
        end
        if (error !== exp_err) begin
            err_cnt++;
            $display("FAIL %s_error got %b want %b", name, error, exp_err);
        end
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_busy got %b want 0", name, busy);
        end
    endtask

    task automatic check_zero(input string name);
        vec_cnt++;
        if ({rx_ready, we, busy, done, error, waddr, wdata} !== 43'd0) begin
            err_cnt++;
            $display("FAIL %s_outputs got rdy=%b we=%b busy=%b done=%b err=%b addr=%h data=%h want all 0",
                     name, rx_ready, we, busy, done, error, waddr, wdata);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("post_reset_idle");
    endtask

    task automatic test_basic();
        begin_load(8'd2);
        send_word(32'hf800_0000, 0);
        send_word(32'hf800_8001, 1);
        finish_load();
        vec_cnt++;
        if (wr_addr_q.size() != 2) begin
            err_cnt++;
            $display("FAIL basic_count got %0d want 2", wr_addr_q.size());
        end else begin
            vec_cnt += 2;
            if ({wr_addr_q[0], wr_data_q[0]} !== {6'd0, 32'hf800_0000}) begin
                err_cnt++;
                $display("FAIL basic_w0 got %h/%h want 00/f8000000", wr_addr_q[0], wr_data_q[0]);
            end
            if ({wr_addr_q[1], wr_data_q[1]} !== {6'd1, 32'hf800_8001}) begin
                err_cnt++;
                $display("FAIL basic_w1 got %h/%h want 01/f8008001", wr_addr_q[1], wr_data_q[1]);
            end
        end
        check_ends("basic", 1'b1, 1'b0);
    endtask

    task automatic test_len_err();
        logic [7:0] lens [2];
        lens[0] = 8'd0;
        lens[1] = 8'd65;
        for (int i = 0; i < 2; i++) begin
            begin_load(lens[i]);
            repeat (3) @(negedge clk);
            check_ends("len_err", 1'b0, 1'b1);
            vec_cnt++;
            if (wr_addr_q.size() != 0) begin
                err_cnt++;
                $display("FAIL len_err_writes got %0d want 0", wr_addr_q.size());
            end
            pulse_start();
            vec_cnt++;
            if ({busy, rx_ready, error} !== 3'b110) begin
                err_cnt++;
                $display("FAIL len_err_recover got busy=%b rdy=%b err=%b want 1 1 0", busy, rx_ready, error);
            end
            send_byte(8'd0, 0);
        end
    endtask

    task automatic test_full();
        logic [31:0] exp [64];
        begin_load(8'd64);
        for (int i = 0; i < 64; i++) begin
            exp[i] = $urandom;
            send_word(exp[i], $urandom_range(0, 3));
        end
        finish_load();
        vec_cnt++;
        if (wr_addr_q.size() != 64) begin
            err_cnt++;
            $display("FAIL full_count got %0d want 64", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                vec_cnt++;
                if ({wr_addr_q[i], wr_data_q[i]} !== {6'(i), exp[i]}) begin
                    err_cnt++;
                    $display("FAIL full_w%0d got %h/%h want %h/%h", i, wr_addr_q[i], wr_data_q[i], 6'(i), exp[i]);
                end
            end
        end
        vec_cnt++;
        if (waddr !== 6'd63) begin
            err_cnt++;
            $display("FAIL full_last_addr got %h want 3f", waddr);
        end
        check_ends("full", 1'b1, 1'b0);
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] good;
        good = 8'hce ^ 8'h01 ^ 8'h0e ^ 8'hcb;
        for (int k = 0; k < 2; k++) begin
            begin_load(8'd1);
            send_word(32'hcb0e_01ce, 0);
            send_byte((k == 0) ? good : (good ^ 8'h01), 0);
            repeat (3) @(negedge clk);
            vec_cnt++;
            if (wr_data_q.size() != 1 || wr_data_q[0] !== 32'hcb0e_01ce) begin
                err_cnt++;
                $display("FAIL cksum_word got n=%0d want one write of cb0e01ce", wr_data_q.size());
            end
            check_ends("cksum", (k == 0), (k != 0));
        end
    endtask
`endif

    task automatic test_reset_mid();
        begin_load(8'd8);
        for (int i = 0; i < 4; i++) send_word(32'h1111_1111 * (i + 1), 0);
        send_byte(8'haa, 0);
        send_byte(8'hbb, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_zero("reset_mid_async");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset_mid_idle");
        vec_cnt++;
        if (wr_addr_q.size() != 4) begin
            err_cnt++;
            $display("FAIL reset_mid_writes got %0d want 4", wr_addr_q.size());
        end
    endtask

    task automatic test_start_ignored();
        begin_load(8'd2);
        send_word(32'hdead_beef, 0);
        send_byte(8'h44, 0);
        pulse_start();
        send_byte(8'h33, 0);
        send_byte(8'h22, 0);
        send_byte(8'h11, 0);
        tb_ck = tb_ck ^ 8'h44 ^ 8'h33 ^ 8'h22 ^ 8'h11;
        finish_load();
        vec_cnt++;
        if (wr_addr_q.size() != 2 || {wr_addr_q[1], wr_data_q[1]} !== {6'd1, 32'h1122_3344}) begin
            err_cnt++;
            $display("FAIL start_ignored got n=%0d want 2 writes ending 01/11223344", wr_addr_q.size());
        end
        check_ends("start_ignored", 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_err();
        test_full();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
